// File: rtl/guess_pkg.sv
// Shared types for the guessing-game player: FSM state encoding and default width.
`default_nettype none
`timescale 1ns/1ps

package guess_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ASK   = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } guesser_state_t;

endpackage

`default_nettype wire

// File: rtl/auto_guesser.sv
// Binary-search player: issues guesses to a comparator oracle, narrows [lo,hi]
// from lt/eq/gt feedback and reports the secret plus the number of guesses.
`default_nettype none
`timescale 1ns/1ps

module auto_guesser
  import guess_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  input  logic             fb_valid,
  input  logic             is_lt,
  input  logic             is_eq,
  input  logic             is_gt,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] found,
  output logic [CNT_W-1:0] guess_count
);

  // Bounds carry one extra bit so lo past the top or hi below zero is visible.
  localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

  guesser_state_t   state_q;
  logic [WIDTH-1:0] guess_q;
  logic [WIDTH-1:0] found_q;
  logic [WIDTH:0]   lo_q;
  logic [WIDTH:0]   hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             fail_q;

  logic [WIDTH:0]   lo_inc_d;
  logic [WIDTH:0]   hi_dec_d;
  logic [WIDTH:0]   sum_d;
  logic             fb_onehot_d;

  assign lo_inc_d    = {1'b0, guess_q} + (WIDTH+1)'(1);
  assign hi_dec_d    = {1'b0, guess_q} - (WIDTH+1)'(1);
  assign sum_d       = lo_q + hi_q;
  assign fb_onehot_d = $onehot({is_lt, is_eq, is_gt});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      guess_q <= '0;
      found_q <= '0;
      lo_q    <= '0;
      hi_q    <= HI_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (start) begin
            lo_q    <= '0;
            hi_q    <= HI_INIT;
            guess_q <= HI_INIT[WIDTH:1];
            cnt_q   <= CNT_W'(1);
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            state_q <= ASK;
          end
        end
        ASK: begin
          if (fb_valid) begin
            if (!fb_onehot_d) begin
              fail_q  <= 1'b1;
              state_q <= FAIL;
            end else if (is_eq) begin
              found_q <= guess_q;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (is_lt) begin
              lo_q    <= lo_inc_d;
              state_q <= CHECK;
            end else begin
              hi_q    <= hi_dec_d;
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if ((lo_q > hi_q) || hi_q[WIDTH]) begin
            fail_q  <= 1'b1;
            state_q <= FAIL;
          end else begin
            // Both bounds fit in WIDTH bits here, so the sum cannot overflow.
            guess_q <= sum_d[WIDTH:1];
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ASK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign guess       = guess_q;
  assign guess_valid = (state_q == ASK);
  assign done        = done_q;
  assign fail        = fail_q;
  assign found       = found_q;
  assign guess_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_auto_guesser.sv
// Bench for auto_guesser: behavioural comparator oracle plus a binary-search
// model that predicts every guess, the final flags and the guess count.
`default_nettype none
`timescale 1ns/1ps

module tb_auto_guesser;

  localparam int WIDTH = 3;
  localparam int CNT_W = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             fb_valid = 1'b0;
  logic             is_lt = 1'b0;
  logic             is_eq = 1'b0;
  logic             is_gt = 1'b0;
  logic             done;
  logic             fail;
  logic [WIDTH-1:0] found;
  logic [CNT_W-1:0] guess_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit exp_ok;
  int gidx = 0;

  auto_guesser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .fb_valid    (fb_valid),
    .is_lt       (is_lt),
    .is_eq       (is_eq),
    .is_gt       (is_gt),
    .done        (done),
    .fail        (fail),
    .found       (found),
    .guess_count (guess_count)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plain binary search over the integer secret; an out-of-range secret
  // models a lying oracle and ends with an empty interval (exp_ok=0).
  task automatic build(input int s);
    int lo, hi, g;
    exp_q.delete();
    exp_ok = 1'b0;
    lo = 0;
    hi = MAXV;
    while (lo <= hi) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      if (g == s) begin
        exp_ok = 1'b1;
        break;
      end
      if (g < s) lo = g + 1;
      else       hi = g - 1;
    end
  endtask

  // Every cycle with guess_valid high: guess and count must match the model;
  // between consecutive guesses of one search guess_valid drops for one cycle.
  initial begin : compare
    bit prev_gv;
    int lowrun;
    prev_gv = 1'b0;
    lowrun  = 0;
    forever begin
      @(negedge clk);
      if (guess_valid) begin
        if (!prev_gv) begin
          if (gidx > 0) check(lowrun == 1, "gap_between_guesses", lowrun, 1);
          gidx++;
          lowrun = 0;
        end
        if (gidx > exp_q.size())
          check(1'b0, "extra_guess", gidx, exp_q.size());
        else begin
          check(int'(guess) == exp_q[gidx-1], "guess", int'(guess), exp_q[gidx-1]);
          check(int'(guess_count) == gidx, "count_in_ask", int'(guess_count), gidx);
        end
      end else begin
        lowrun++;
      end
      prev_gv = guess_valid;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(guess_valid || done || fail) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check(1'b0, "timeout_waiting_guess", n, 50);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int s);
    fb_valid = 1'b1;
    is_lt = (int'(guess) < s);
    is_eq = (int'(guess) == s);
    is_gt = (int'(guess) > s);
    @(posedge clk); #1;
    fb_valid = 1'b0; is_lt = 1'b0; is_eq = 1'b0; is_gt = 1'b0;
  endtask

  task automatic do_search(input int s, input int dly, input bit repulse, input int lit_cnt);
    build(s);
    gidx = 0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      wait_ready();
      if (done || fail || !guess_valid) break;
      for (int d = 0; d < dly; d++) begin
        start = repulse && (d == 0);
        @(posedge clk); #1;
      end
      start = 1'b0;
      feed(s);
    end
    wait_ready();
    check(done == exp_ok, "done", int'(done), int'(exp_ok));
    check(fail == !exp_ok, "fail", int'(fail), int'(!exp_ok));
    if (exp_ok) check(int'(found) == s, "found", int'(found), s);
    check(int'(guess_count) == exp_q.size(), "count_final", int'(guess_count), exp_q.size());
    check(int'(guess_count) <= WIDTH + 1, "count_max", int'(guess_count), WIDTH + 1);
    if (lit_cnt >= 0) check(int'(guess_count) == lit_cnt, "count_literal", int'(guess_count), lit_cnt);
    repeat (3) @(posedge clk);
    #1;
    check(done == exp_ok && fail == !exp_ok && !guess_valid, "flags_persist",
          {done, fail, guess_valid}, {exp_ok, !exp_ok, 1'b0});
  endtask

  initial begin : stim
    int lit7[4];
    int lit0[3];
    lit7 = '{3, 5, 6, 7};
    lit0 = '{3, 1, 0};

    // Hand-computed sequences pin the model itself.
    build(7);
    check(exp_q.size() == 4, "model_len_7", exp_q.size(), 4);
    for (int i = 0; i < 4; i++) check(exp_q[i] == lit7[i], "model_seq_7", exp_q[i], lit7[i]);
    build(0);
    check(exp_q.size() == 3, "model_len_0", exp_q.size(), 3);
    for (int i = 0; i < 3; i++) check(exp_q[i] == lit0[i], "model_seq_0", exp_q[i], lit0[i]);
    build(8);
    check(exp_ok == 1'b0 && exp_q.size() == 4, "model_lie_8", exp_q.size(), 4);

    repeat (3) @(posedge clk);
    #1;
    check({guess, guess_valid, done, fail, found, guess_count} == '0, "reset_outputs",
          int'({guess, guess_valid, done, fail, found, guess_count}), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    do_search(5, 0, 1'b0, 2);
    do_search(7, 3, 1'b0, 4);
    do_search(0, 0, 1'b0, 3);
    do_search(8, 1, 1'b0, 4);
    do_search(-1, 0, 1'b0, 3);

    // Feedback not one-hot at the first guess.
    build(5);
    gidx = 0;
    pulse_start();
    wait_ready();
    fb_valid = 1'b1; is_lt = 1'b1; is_gt = 1'b1;
    @(posedge clk); #1;
    fb_valid = 1'b0; is_lt = 1'b0; is_gt = 1'b0;
    check(fail && !done && !guess_valid, "not_onehot_fail", {fail, done, guess_valid}, 3'b100);
    check(int'(guess_count) == 1, "not_onehot_count", int'(guess_count), 1);

    do_search(4, 2, 1'b1, 3);

    // Asynchronous reset after the second guess has been issued.
    build(6);
    gidx = 0;
    pulse_start();
    wait_ready();
    feed(6);
    wait_ready();
    check(int'(guess) == 5 && guess_valid, "second_guess_before_reset", int'(guess), 5);
    #1 reset_n = 1'b0;
    #1;
    check({guess, guess_valid, done, fail, found, guess_count} == '0, "async_reset_outputs",
          int'({guess, guess_valid, done, fail, found, guess_count}), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    do_search(2, 0, 1'b0, 3);

    for (int s = 0; s <= MAXV; s++) do_search(s, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
